gaussian_window_ctrl: RTL

GAUSSIAN_WINDOW_CTRL -- requirements
Module: gaussian_window_ctrl

---
 rtl/gauss_pkg.sv | 25 ++
 rtl/gauss_line_buf.sv | 33 +++
 rtl/gaussian_window_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/gauss_pkg.sv
// Shared types for the 3x3 Gaussian window controller: FSM state encoding
// and the row-major window slot indices (0 = top-left, 8 = bottom-right).
package gauss_pkg;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_ISSUE0,
        ST_ISSUE1,
        ST_CAPTURE,
        ST_OUT
    } state_t;

    localparam int WIN_N  = 9;

    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

endpackage

// File: rtl/gauss_line_buf.sv
// Two single-port line buffers. A write at column i_addr pushes the older
// line down (lb0 -> lb1) and stores the new pixel in lb0. The read is
// combinational, so the window sees the pre-write contents in the same cycle.
module gauss_line_buf #(
    parameter int IMG_W = 64,
    parameter int DW    = 27,
    parameter int AW    = $clog2(IMG_W)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_addr,
    input  logic signed [DW-1:0] i_din,
    output logic signed [DW-1:0] o_lb0,
    output logic signed [DW-1:0] o_lb1
);

    logic signed [DW-1:0] r_lb0 [IMG_W];
    logic signed [DW-1:0] r_lb1 [IMG_W];

    assign o_lb0 = r_lb0[i_addr];
    assign o_lb1 = r_lb1[i_addr];

    // Shift the column down one line on every accepted pixel.
    // NOTE: memory arrays carry no reset; row/col gating upstream keeps
    // stale contents from ever reaching a completed window.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_lb1[i_addr] <= r_lb0[i_addr];
            r_lb0[i_addr] <= i_din;
        end
    end

endmodule

// File: rtl/gaussian_window_ctrl.sv
// Raster-scan 3x3 window builder feeding an external Gaussian datapath.
// Accepts one pixel at a time, issues each interior window for two cycles,
// captures the result and presents it on a valid/ready output.
module gaussian_window_ctrl
    import gauss_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int DW    = 27
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_pixel,
    output logic                 g_start,
    output logic signed [DW-1:0] g_win0,
    output logic signed [DW-1:0] g_win1,
    output logic signed [DW-1:0] g_win2,
    output logic signed [DW-1:0] g_win3,
    output logic signed [DW-1:0] g_win4,
    output logic signed [DW-1:0] g_win5,
    output logic signed [DW-1:0] g_win6,
    output logic signed [DW-1:0] g_win7,
    output logic signed [DW-1:0] g_win8,
    input  logic signed [DW-1:0] g_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    logic                 r_run;
    logic                 r_last_pend;
    logic signed [DW-1:0] r_win [WIN_N];
    logic signed [DW-1:0] r_out_data;
    logic                 r_out_last;
    logic signed [DW-1:0] w_lb0;
    logic signed [DW-1:0] w_lb1;
    logic                 w_accept;
    logic                 w_complete;
    logic                 w_last_px;

    assign w_complete = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_last_px  = (r_col == COL_MAX) && (r_row == ROW_MAX);

    gauss_line_buf #(
        .IMG_W (IMG_W),
        .DW    (DW)
    ) u_line_buf (
        .clk    (clk),
        .i_we   (w_accept),
        .i_addr (r_col),
        .i_din  (in_pixel),
        .o_lb0  (w_lb0),
        .o_lb1  (w_lb1)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode; clear overrides every transition.
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and a latch is never inferred.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        w_accept  = 1'b0;
        g_start   = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (r_state)
            ST_FILL: begin
                in_ready = r_run && !clear;
                w_accept = in_ready && in_valid;
                if (w_accept && w_complete) begin
                    w_next = ST_ISSUE0;
                end
            end
            ST_ISSUE0: begin
                g_start = 1'b1;
                busy    = 1'b1;
                w_next  = ST_ISSUE1;
            end
            ST_ISSUE1: begin
                g_start = 1'b1;
                busy    = 1'b1;
                w_next  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                busy   = 1'b1;
                w_next = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    w_next = ST_FILL;
                end
            end
            default: w_next = ST_FILL;
        endcase
        if (clear) begin
            w_next = ST_FILL;
        end
    end

    // Raster counters, window shift register and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_run       <= 1'b0;
            r_last_pend <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            for (int i = 0; i < WIN_N; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_run <= 1'b1;
            if (clear) begin
                r_col       <= '0;
                r_row       <= '0;
                r_last_pend <= 1'b0;
            end else begin
                if (w_accept) begin
                    if (r_col == COL_MAX) begin
                        r_col <= '0;
                        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    r_last_pend   <= w_last_px;
                    r_win[WIN_TL] <= r_win[WIN_TC];
                    r_win[WIN_TC] <= r_win[WIN_TR];
                    r_win[WIN_TR] <= w_lb1;
                    r_win[WIN_ML] <= r_win[WIN_MC];
                    r_win[WIN_MC] <= r_win[WIN_MR];
                    r_win[WIN_MR] <= w_lb0;
                    r_win[WIN_BL] <= r_win[WIN_BC];
                    r_win[WIN_BC] <= r_win[WIN_BR];
                    r_win[WIN_BR] <= in_pixel;
                end
                if (r_state == ST_CAPTURE) begin
                    r_out_data <= g_result;
                    r_out_last <= r_last_pend;
                end
            end
        end
    end

    assign out_data = r_out_data;
    assign out_last = r_out_last;

    assign g_win0 = r_win[WIN_TL];
    assign g_win1 = r_win[WIN_TC];
    assign g_win2 = r_win[WIN_TR];
    assign g_win3 = r_win[WIN_ML];
    assign g_win4 = r_win[WIN_MC];
    assign g_win5 = r_win[WIN_MR];
    assign g_win6 = r_win[WIN_BL];
    assign g_win7 = r_win[WIN_BC];
    assign g_win8 = r_win[WIN_BR];

endmodule
